unison_readout_capture: RTL and testbench

- Wishbone slave directly downstream of the digital_unison instances.
- Continuously samples one selected channel's 2-bit read_out_I and 2-bit read_out_Q streams on each rising edge of that channel's clk_master.
- Packs 8 samples into a 32-bit word and buffers words in a FIFO that firmware drains over Wishbone, replacing manual LA polling.
- One clock; reset is synchronous and active-high. wb_clk_i is the clock, wb_rst_i is the reset.

---
 rtl/unison_readout_capture.sv | 195 +++++++++++++++++++
 tb/tb_unison_readout_capture.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unison_readout_capture.sv
// Wishbone-readable capture of one digital_unison channel's I/Q readout stream.
// Samples are packed 8 nibbles to a word and queued in a FIFO for firmware to drain.
module unison_readout_capture #(
  parameter int unsigned NUM_CH     = 6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [NUM_CH-1:0]     clk_master,
  input  logic [4*NUM_CH-1:0]   read_out,
  output logic                  irq_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // control register fields
  logic             en_q;
  logic [3:0]       sel_q;
  logic [7:0]       thresh_q;

  // synchronizer / edge detector
  logic             clk_s1, clk_s2, clk_prev;
  logic [3:0]       nib_s1, nib_s2;
  logic [1:0]       settle_q;

  // packer
  logic [2:0]       k_q;
  logic [31:0]      word_q;

  // FIFO
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [CH_W-1:0]  ch_c;
  logic             raw_clk_c;
  logic [3:0]       raw_nib_c;
  logic             hit_c, req_c, wr_c, rd_c, pop_c;
  logic [1:0]       off_c;
  logic             ctrl_wr_c, new_en_c, clr_c, sel_chg_c, discard_c, ovf_clr_c;
  logic [3:0]       new_sel_c;
  logic [7:0]       new_thresh_c;
  logic             edge_c, cap_c, push_req_c, push_ok_c, drop_c;
  logic             full_c, empty_c;
  logic [31:0]      push_word_c, status_c, rdata_c;
  logic             unused_c;

  // Channel select; out-of-range selections fall back to channel 0
  always_comb begin
    ch_c      = ({28'd0, sel_q} < 32'(NUM_CH)) ? CH_W'(sel_q) : '0;
    raw_clk_c = 1'b0;
    raw_nib_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_c == CH_W'(c)) begin
        raw_clk_c = clk_master[c];
        raw_nib_c = read_out[4*c +: 4];
      end
    end
  end

  // Bus decode, register-write effects and capture/FIFO decisions
  always_comb begin
    hit_c        = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    req_c        = wbs_stb_i & wbs_cyc_i & hit_c & ~wbs_ack_o;
    wr_c         = req_c & wbs_we_i;
    rd_c         = req_c & ~wbs_we_i;
    off_c        = wbs_adr_i[3:2];
    full_c       = (count_q == CNT_W'(FIFO_DEPTH));
    empty_c      = (count_q == '0);
    pop_c        = rd_c && (off_c == 2'd2) && !empty_c;

    ctrl_wr_c    = wr_c && (off_c == 2'd0);
    new_en_c     = wbs_sel_i[0] ? wbs_dat_i[0]     : en_q;
    new_sel_c    = wbs_sel_i[0] ? wbs_dat_i[7:4]   : sel_q;
    new_thresh_c = wbs_sel_i[2] ? wbs_dat_i[23:16] : thresh_q;
    clr_c        = ctrl_wr_c && wbs_sel_i[1] && wbs_dat_i[8];
    sel_chg_c    = ctrl_wr_c && (new_sel_c != sel_q);
    discard_c    = (ctrl_wr_c && en_q && !new_en_c) || sel_chg_c || clr_c;
    ovf_clr_c    = wr_c && (off_c == 2'd1) && wbs_sel_i[1] && wbs_dat_i[9];

    edge_c       = clk_s2 && !clk_prev && (settle_q == 2'd0);
    cap_c        = edge_c && en_q && !discard_c;
    push_req_c   = cap_c && (k_q == 3'd7);
    push_word_c  = {nib_s2, word_q[27:0]};
    push_ok_c    = push_req_c && !clr_c && (!full_c || pop_c);
    drop_c       = push_req_c && !clr_c && full_c && !pop_c;

    status_c     = {18'd0, k_q, full_c, ovf_q, empty_c, 8'(count_q)};
    rdata_c      = '0;
    case (off_c)
      2'd0:    rdata_c = {8'd0, thresh_q, 8'd0, sel_q, 3'd0, en_q};
      2'd1:    rdata_c = status_c;
      2'd2:    rdata_c = empty_c ? 32'd0 : mem[rd_ptr_q];
      default: rdata_c = '0;
    endcase
  end

  assign unused_c = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_dat_i[15:10],
                      wbs_dat_i[3:1], wbs_sel_i[3]};

  // Wishbone single-cycle response
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req_c;
      wbs_dat_o <= rd_c ? rdata_c : 32'd0;
    end
  end

  // CTRL register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q     <= 1'b0;
      sel_q    <= '0;
      thresh_q <= '0;
    end else if (ctrl_wr_c) begin
      en_q     <= new_en_c;
      sel_q    <= new_sel_c;
      thresh_q <= new_thresh_c;
    end
  end

  // Two-flop synchronizers; flushed on a channel change and edges held off until refilled
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || sel_chg_c) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      nib_s1   <= '0;
      nib_s2   <= '0;
      settle_q <= 2'd3;
    end else begin
      clk_s1   <= raw_clk_c;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      nib_s1   <= raw_nib_c;
      nib_s2   <= nib_s1;
      if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
    end
  end

  // Nibble packer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || discard_c) begin
      k_q    <= '0;
      word_q <= '0;
    end else if (cap_c) begin
      word_q[{k_q, 2'b00} +: 4] <= nib_s2;
      k_q                       <= k_q + 3'd1;
    end
  end

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (push_ok_c) mem[wr_ptr_q] <= push_word_c;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr_c) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (pop_c && !push_ok_c) count_q <= count_q - CNT_W'(1);
      if (drop_c)         ovf_q <= 1'b1;
      else if (ovf_clr_c) ovf_q <= 1'b0;
    end
  end

  // Threshold interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_o <= 1'b0;
    else          irq_o <= en_q && (thresh_q != 8'd0) && (32'(count_q) >= 32'(thresh_q));
  end

endmodule

// File: tb/tb_unison_readout_capture.sv
// Directed bench for unison_readout_capture with a queue-based reference model.
module tb_unison_readout_capture;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic [NUM_CH-1:0]   cm;
  logic [4*NUM_CH-1:0] ro;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_en;
  int          m_k, m_sel, m_thresh;
  logic [31:0] m_word;

  // expectations consumed by the compare process
  bit          cmp_on = 1'b0;
  bit          chk_irq = 1'b0;
  bit          exp_ack = 1'b0;
  logic [31:0] exp_dat = '0;

  unison_readout_capture #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .clk_master(cm), .read_out(ro), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // ---------------- model ----------------
  function automatic void m_reset();
    mq.delete();
    m_ovf = 0; m_en = 0; m_k = 0; m_sel = 0; m_thresh = 0; m_word = '0;
  endfunction

  function automatic bit m_irq();
    return m_en && (m_thresh != 0) && (mq.size() >= m_thresh);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(mq.size()) & 32'hFF;
    s[8]     = (mq.size() == 0);
    s[9]     = m_ovf;
    s[10]    = (mq.size() == DEPTH);
    s[13:11] = 3'(m_k);
    return s;
  endfunction

  function automatic logic [31:0] m_ctrl();
    return (32'(m_thresh) << 16) | (32'(m_sel) << 4) | 32'(m_en);
  endfunction

  function automatic void m_sample(input int ch, input logic [3:0] nib);
    int eff;
    eff = (m_sel < NUM_CH) ? m_sel : 0;
    if (!m_en || ch != eff) return;
    m_word[4*m_k +: 4] = nib;
    if (m_k == 7) begin
      if (mq.size() < DEPTH) mq.push_back(m_word);
      else m_ovf = 1;
    end
    m_k = (m_k + 1) % 8;
  endfunction

  function automatic void m_ctrl_write(input logic [31:0] d, input logic [3:0] s);
    bit ne; int ns;
    ne = s[0] ? d[0] : m_en;
    ns = s[0] ? int'(d[7:4]) : m_sel;
    if (s[2]) m_thresh = int'(d[23:16]);
    if ((m_en && !ne) || ns != m_sel || (s[1] && d[8])) begin
      m_k = 0; m_word = '0;
    end
    if (s[1] && d[8]) begin
      mq.delete(); m_ovf = 0;
    end
    m_en = ne; m_sel = ns;
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'd0;
    return mq.pop_front();
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_on) begin
        checks++;
        if (ack !== exp_ack) begin
          errors++;
          $display("FAIL ack_cycle: got %0b expected %0b at %0t", ack, exp_ack, $time);
        end
        checks++;
        if (rdat !== (exp_ack ? exp_dat : 32'd0)) begin
          errors++;
          $display("FAIL dat_cycle: got 0x%08h expected 0x%08h at %0t", rdat,
                   exp_ack ? exp_dat : 32'd0, $time);
        end
        if (chk_irq) begin
          checks++;
          if (irq !== m_irq()) begin
            errors++;
            $display("FAIL irq_cycle: got %0b expected %0b at %0t", irq, m_irq(), $time);
          end
        end
      end
    end
  end

  // ---------------- bus and stimulus tasks ----------------
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit hit, input logic [31:0] er,
                         output logic [31:0] rd, output logic ak);
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    exp_ack = hit; exp_dat = (hit && !w) ? er : 32'd0; chk_irq = 1;
    @(posedge clk);
    #1;
    rd = rdat; ak = ack;
    @(negedge clk);
    stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0;
    exp_ack = 0; exp_dat = 0; chk_irq = 0;
  endtask

  task automatic rd_status(output logic [31:0] rd);
    logic ak;
    wb_xfer(0, BASE + 32'h4, 0, 4'hF, 1, m_status(), rd, ak);
  endtask

  task automatic rd_ctrl(output logic [31:0] rd);
    logic ak;
    wb_xfer(0, BASE, 0, 4'hF, 1, m_ctrl(), rd, ak);
  endtask

  task automatic rd_data(output logic [31:0] rd);
    logic ak;
    logic [31:0] e;
    e = (mq.size() != 0) ? mq[0] : 32'd0;
    wb_xfer(0, BASE + 32'h8, 0, 4'hF, 1, e, rd, ak);
    void'(m_pop());
  endtask

  task automatic wr_ctrl(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic ak;
    wb_xfer(1, BASE, d, s, 1, 0, rd, ak);
    m_ctrl_write(d, s);
  endtask

  task automatic wr_status(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic ak;
    wb_xfer(1, BASE + 32'h4, d, s, 1, 0, rd, ak);
    if (s[1] && d[9]) m_ovf = 0;
  endtask

  // one clk_master period of 10 wb clocks (5 high, 5 low)
  task automatic send_sample(input int ch, input logic [3:0] nib);
    repeat (2) @(negedge clk);
    ro[4*ch +: 4] = nib;
    cm[ch] = 1'b1;
    repeat (5) @(negedge clk);
    cm[ch] = 1'b0;
    repeat (5) @(negedge clk);
    m_sample(ch, nib);
  endtask

  task automatic send_word(input int ch, input logic [31:0] w);
    for (int j = 0; j < 8; j++) send_sample(ch, w[4*j +: 4]);
  endtask

  // 8th-sample push lands on the same edge as a DATA pop
  task automatic push_with_pop(input int ch, input logic [3:0] nib, output logic [31:0] rd);
    logic [31:0] head;
    repeat (2) @(negedge clk);
    ro[4*ch +: 4] = nib;
    cm[ch] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    head = m_pop();
    stb = 1; cyc = 1; we = 0; adr = BASE + 32'h8; sel = 4'hF;
    exp_ack = 1; exp_dat = head;
    @(posedge clk);
    #1;
    rd = rdat;
    @(negedge clk);
    stb = 0; cyc = 0; sel = 0;
    exp_ack = 0; exp_dat = 0;
    m_sample(ch, nib);
    repeat (2) @(negedge clk);
    cm[ch] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r;
    logic ak;
    logic [31:0] w;

    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; wdat = 0; adr = 0;
    cm = '0; ro = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_dat", rdat, 0);
    chk("reset_irq", 32'(irq), 0);
    rst = 0;
    cmp_on = 1;

    rd_status(r);
    chk("status_after_reset", r, 32'h0000_0100);
    rd_data(r);
    chk("data_empty", r, 32'h0);

    // basic packing on channel 1
    wr_ctrl(32'h0000_0011, 4'hF);
    for (int j = 1; j <= 8; j++) send_sample(1, 4'(j));
    rd_data(r);
    chk("first_word", r, 32'h8765_4321);
    rd_status(r);
    chk("status_drained", r, 32'h0000_0100);

    // partial word discarded on disable
    send_sample(1, 4'hA); send_sample(1, 4'hB); send_sample(1, 4'hC);
    rd_status(r);
    chk("status_k3", r, 32'h0000_1900);
    wr_ctrl(32'h0000_0010, 4'hF);
    rd_status(r);
    chk("status_k_cleared", r, 32'h0000_0100);
    wr_ctrl(32'h0000_0011, 4'hF);
    send_sample(2, 4'h5);               // unselected channel, ignored
    send_word(1, 32'hFFFF_FFFF);
    rd_status(r);
    chk("status_one_word", r, 32'h0000_0001);
    rd_data(r);
    chk("all_f_word", r, 32'hFFFF_FFFF);

    // overfill: 17 words, last dropped
    for (int wi = 0; wi < 17; wi++) begin
      for (int j = 0; j < 8; j++) w[4*j +: 4] = 4'((wi + j) & 15);
      send_word(1, w);
    end
    rd_status(r);
    chk("status_full_ovf", r, 32'h0000_0610);
    rd_data(r);
    chk("overflow_head_intact", r, 32'h7654_3210);
    wr_status(32'h0000_0200, 4'b0010);
    rd_status(r);
    chk("status_ovf_cleared", r, 32'h0000_000F);

    // pop coinciding with a push while full
    send_word(1, 32'h3333_3333);
    rd_status(r);
    chk("status_full_again", r, 32'h0000_0410);
    for (int j = 0; j < 7; j++) send_sample(1, 4'h9);
    push_with_pop(1, 4'hA, r);
    chk("coincident_pop_data", r, 32'h8765_4321);
    rd_status(r);
    chk("status_coincident", r, 32'h0000_0410);

    // clear
    wr_ctrl(32'h0000_0100, 4'b0010);
    rd_status(r);
    chk("status_after_clr", r, 32'h0000_0100);

    // threshold interrupt
    wr_ctrl(32'h0002_0011, 4'b0101);
    rd_ctrl(r);
    chk("ctrl_readback", r, 32'h0002_0011);
    send_word(1, 32'h1111_1111);
    chk("irq_below_thresh", 32'(irq), 0);
    send_word(1, 32'h2222_2222);
    repeat (2) @(negedge clk);
    chk("irq_at_thresh", 32'(irq), 1);
    rd_data(r);
    chk("irq_pop_data", r, 32'h1111_1111);
    repeat (2) @(negedge clk);
    chk("irq_after_pop", 32'(irq), 0);
    wr_ctrl(32'h0000_0100, 4'b0010);

    // reserved offset and out-of-window address
    wb_xfer(0, BASE + 32'hC, 0, 4'hF, 1, 0, r, ak);
    chk("reserved_read_ack", 32'(ak), 1);
    wb_xfer(1, BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, 1, 0, r, ak);
    chk("reserved_write_ack", 32'(ak), 1);
    wb_xfer(0, BASE + 32'h10, 0, 4'hF, 0, 0, r, ak);
    chk("outside_no_ack", 32'(ak), 0);

    // out-of-range sel falls back to channel 0
    wr_ctrl(32'h0000_0071, 4'b0001);
    send_sample(1, 4'h4);               // ignored
    for (int j = 0; j < 8; j++) send_sample(0, 4'(j + 8));
    rd_data(r);
    chk("sel_fallback_word", r, 32'hFEDC_BA98);

    // reset with state pending
    send_word(0, 32'h1234_5678);
    send_sample(0, 4'h1);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    m_reset();
    rd_status(r);
    chk("status_after_rerst", r, 32'h0000_0100);
    rd_ctrl(r);
    chk("ctrl_after_rerst", r, 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
